// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder: synchronise, debounce and decode 7-segment lines into hex digits over valid/ready.
//   clk, rst          rising-edge clock, synchronous active-high reset
//   seg_in[6:0]       asynchronous segment lines, bit0=a .. bit6=g
//   digit_out/valid   1-entry output register, held while valid & !ready
//   digit_ready       consumer accept
//   blank             last committed pattern was all-off
//   err_cnt           saturating count of committed non-hex patterns
//   overrun           sticky: hex digit dropped because output was occupied
//   clr_status        clears err_cnt and overrun (wins over same-cycle set)
module seg7_capture_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit_out,
  output logic             digit_valid,
  input  logic             digit_ready,
  output logic             blank,
  output logic [ERR_W-1:0] err_cnt,
  output logic             overrun,
  input  logic             clr_status
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  typedef enum logic {IDLE, SETTLE} state_t;
  state_t state;
  logic [6:0] s1, seg_s, cand, last;
  logic [CW-1:0] cnt;
  logic commit, new_pat, hit;
  logic [3:0] val;
  // The cycle that loads a new candidate counts as the first held cycle.
  assign commit = (seg_s != cand) ? (STABLE_CYCLES == 1) : (state == SETTLE && int'(cnt) + 2 == STABLE_CYCLES);
  assign new_pat = commit && seg_s != last;
  always_comb begin
    hit = 1'b1;
    val = 4'h0;
    case (seg_s)
      7'h3F: val = 4'h0;
      7'h06: val = 4'h1;
      7'h5B: val = 4'h2;
      7'h4F: val = 4'h3;
      7'h66: val = 4'h4;
      7'h6D: val = 4'h5;
      7'h7D: val = 4'h6;
      7'h07: val = 4'h7;
      7'h7F: val = 4'h8;
      7'h6F: val = 4'h9;
      7'h77: val = 4'hA;
      7'h7C: val = 4'hB;
      7'h39: val = 4'hC;
      7'h5E: val = 4'hD;
      7'h79: val = 4'hE;
      7'h71: val = 4'hF;
      default: hit = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      seg_s <= '0;
      cand <= '0;
      last <= '0;
      cnt <= '0;
      state <= IDLE;
      digit_out <= '0;
      digit_valid <= 1'b0;
      blank <= 1'b1;
      err_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      s1 <= seg_in;
      seg_s <= s1;
      if (seg_s != cand) begin
        cand <= seg_s;
        cnt <= '0;
        state <= commit ? IDLE : SETTLE;
      end else if (state == SETTLE) begin
        cnt <= cnt + 1'b1;
        if (commit) state <= IDLE;
      end
      if (digit_valid && digit_ready) digit_valid <= 1'b0;
      if (new_pat) begin
        last <= seg_s;
        blank <= seg_s == 7'h00;
        if (hit) begin
          if (!digit_valid || digit_ready) begin
            digit_out <= val;
            digit_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else if (seg_s != 7'h00) begin
          err_cnt <= (&err_cnt) ? err_cnt : err_cnt + 1'b1;
        end
      end
      if (clr_status) begin
        err_cnt <= '0;
        overrun <= 1'b0;
      end
    end
  end
endmodule
